// File: rtl/onchip_ram_pkg.sv
// onchip_ram_pkg
// Shared constants and types for the on-chip RAM arbiter slice.
//   DATA_W / BE_W   : RAM data width and byte-lane count
//   ADDR_W / DEPTH  : word address width and number of implemented words
//   BOUNDS_ERR_DATA : read data returned for out-of-range reads when the
//                     ONCHIP_RAM_ARB_BOUNDS_CHECK_EN build option is enabled
//   owner_e         : identifies which master a read response belongs to
package onchip_ram_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 13;
   localparam int DEPTH  = 5120;
   localparam int BE_W   = DATA_W / 8;
   localparam logic [DATA_W-1:0] BOUNDS_ERR_DATA = 32'hDEAD_BEEF;
   localparam logic [ADDR_W-1:0] DEPTH_LIMIT     = ADDR_W'(DEPTH);

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } owner_e;

   // True when a word address maps onto an implemented RAM word.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
      return addr < DEPTH_LIMIT;
   endfunction
endpackage

// File: rtl/onchip_ram_arbiter_if.sv
// onchip_ram_arbiter_if
// One Avalon-MM requester link between a master and the RAM arbiter.
//   address, byteenable, read, write, writedata : master -> arbiter
//   waitrequest, readdata, readdatavalid        : arbiter -> master
// Handshake: a transfer is accepted in every cycle where (read | write) is
// high and waitrequest is low; while waitrequest is high the master holds
// its request fields stable. Reads answer with readdatavalid exactly one
// cycle after acceptance; writes produce no response.
interface onchip_ram_arbiter_if;
   import onchip_ram_pkg::*;

   logic [ADDR_W-1:0] address;
   logic [BE_W-1:0]   byteenable;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/onchip_ram_arbiter_rr_arb2.sv
// rr_arb2
// Combinational two-requester round-robin grant function.
//   req[1:0]  in  : request per master
//   prio_ptr  in  : master preferred when both request
//   grant[1:0]out : one-hot grant (zero when nobody requests)
//   next_ptr  out : pointer value after this cycle (points away from winner,
//                   unchanged when idle)
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio_ptr,
   output logic [1:0] grant,
   output logic       next_ptr
);
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = prio_ptr ? 2'b10 : 2'b01;
      end

      next_ptr = prio_ptr;
      if (grant[0]) begin
         next_ptr = 1'b1;
      end else if (grant[1]) begin
         next_ptr = 1'b0;
      end
   end
endmodule

// File: rtl/onchip_ram_arbiter.sv
// onchip_ram_arbiter
// Shares one single-port, 1-cycle-latency on-chip RAM between two Avalon-MM
// masters with round-robin arbitration and full one-transfer-per-cycle
// throughput.
//   clk, reset      : clock, asynchronous active-high reset
//   m0, m1          : requester links (slave side of onchip_ram_arbiter_if)
//   ram_*           : RAM slave port (address/byteenable/chipselect/write/
//                     writedata/clken out, readdata in)
//   bounds_err      : sticky out-of-range flag, present only when the build
//                     macro ONCHIP_RAM_ARB_BOUNDS_CHECK_EN is defined
module onchip_ram_arbiter
   import onchip_ram_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   onchip_ram_arbiter_if.slave m0,
   onchip_ram_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [BE_W-1:0]     ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [DATA_W-1:0]   ram_writedata,
   output logic                ram_clken,
   input  logic [DATA_W-1:0]   ram_readdata
`ifdef ONCHIP_RAM_ARB_BOUNDS_CHECK_EN
   ,
   output logic                bounds_err
`endif
);
   logic [1:0]        req;
   logic [1:0]        grant;
   logic              next_ptr;
   logic              prio_ptr_q, prio_ptr_d;
   logic              rd_pend_q, rd_pend_d;
   owner_e            rd_owner_q, rd_owner_d;
   owner_e            win;
   logic              accept;
   logic              win_write;
   logic              win_read;
   logic              in_range;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] rsp_data;

   // Requests are masked during reset so nothing is granted or forwarded.
   assign req = {m1.read | m1.write, m0.read | m0.write} & {2{~reset}};

   rr_arb2 u_rr_arb2 (
      .req      (req),
      .prio_ptr (prio_ptr_q),
      .grant    (grant),
      .next_ptr (next_ptr)
   );

   always_comb begin
      accept    = |grant;
      win       = grant[1] ? M1 : M0;
      win_write = (win == M1) ? m1.write : m0.write;
      win_addr  = (win == M1) ? m1.address : m0.address;
      // A granted request that is not a write is a read; write wins when
      // both strobes are set.
      win_read  = accept & ~win_write;
   end

`ifdef ONCHIP_RAM_ARB_BOUNDS_CHECK_EN
   logic rd_oob_q, rd_oob_d;
   logic bounds_err_q, bounds_err_d;

   assign in_range = addr_in_range(win_addr);

   always_comb begin
      rd_oob_d     = win_read & ~in_range;
      bounds_err_d = bounds_err_q | (accept & ~in_range);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_oob_q     <= 1'b0;
         bounds_err_q <= 1'b0;
      end else begin
         rd_oob_q     <= rd_oob_d;
         bounds_err_q <= bounds_err_d;
      end
   end

   assign bounds_err = bounds_err_q;
   assign rsp_data   = rd_oob_q ? BOUNDS_ERR_DATA : ram_readdata;
`else
   assign in_range = 1'b1;
   assign rsp_data = ram_readdata;
`endif

   always_comb begin
      ram_address    = win_addr;
      ram_byteenable = (win == M1) ? m1.byteenable : m0.byteenable;
      ram_writedata  = (win == M1) ? m1.writedata : m0.writedata;
      ram_chipselect = accept & in_range;
      ram_write      = accept & win_write & in_range;
      ram_clken      = ~reset;

      m0.waitrequest = ~grant[0];
      m1.waitrequest = ~grant[1];

      m0.readdatavalid = rd_pend_q & (rd_owner_q == M0);
      m1.readdatavalid = rd_pend_q & (rd_owner_q == M1);
      m0.readdata      = m0.readdatavalid ? rsp_data : '0;
      m1.readdata      = m1.readdatavalid ? rsp_data : '0;
   end

   always_comb begin
      prio_ptr_d = next_ptr;
      rd_pend_d  = win_read;
      rd_owner_d = win_read ? win : rd_owner_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_ptr_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= M0;
      end else begin
         prio_ptr_q <= prio_ptr_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end
endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// tb_onchip_ram_arbiter
// Self-checking bench for onchip_ram_arbiter. A behavioural RAM sits on the
// RAM port; a reference model (word map + "alternate between contenders"
// rule + expected response queue) predicts waitrequest, chipselect and the
// read responses each cycle. Define ONCHIP_RAM_ARB_BOUNDS_CHECK_EN to also
// exercise the bounds-check build.
module tb_onchip_ram_arbiter;
   import onchip_ram_pkg::*;

`ifdef ONCHIP_RAM_ARB_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
   logic bounds_err;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   onchip_ram_arbiter_if m0_if ();
   onchip_ram_arbiter_if m1_if ();

   logic [ADDR_W-1:0] ram_address;
   logic [BE_W-1:0]   ram_byteenable;
   logic              ram_chipselect;
   logic              ram_write;
   logic [DATA_W-1:0] ram_writedata;
   logic              ram_clken;
   logic [DATA_W-1:0] ram_readdata;

   onchip_ram_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .m0             (m0_if),
      .m1             (m1_if),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .ram_clken      (ram_clken),
      .ram_readdata   (ram_readdata)
`ifdef ONCHIP_RAM_ARB_BOUNDS_CHECK_EN
      ,
      .bounds_err     (bounds_err)
`endif
   );

   // Behavioural single-port RAM with a registered read port.
   logic [31:0] mem [0:8191];
   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = '0;
      ram_readdata = '0;
   end
   always @(posedge clk) begin
      if (ram_clken && ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         end else begin
            ram_readdata <= mem[ram_address];
         end
      end
   end

   // ---------------- reference model / scoreboard ----------------
   logic [31:0] ref_mem [int];
   int          last_win;          // master that won most recently
   logic [32:0] exp_q [$];         // {owner, data} of outstanding read
   int          errors = 0;
   int          checks = 0;
   logic        acc [2];
   logic        got_wait [2];
   logic        got_valid [2];
   logic [31:0] got_data [2];
   logic        got_cs;

   function automatic logic [31:0] ref_read(input logic [12:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
   endfunction

   function automatic bit oob(input logic [12:0] a);
      return BOUNDS_EN && (int'(a) >= 5120);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input int m, input logic rd, input logic wr, input logic [12:0] a,
                        input logic [3:0] be, input logic [31:0] d);
      if (m == 0) begin
         m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
         m0_if.byteenable = be; m0_if.writedata = d;
      end else begin
         m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
         m1_if.byteenable = be; m1_if.writedata = d;
      end
   endtask

   // One bus cycle: entered just after a falling edge with inputs set,
   // returns at the next falling edge.
   task automatic cycle();
      logic        rd [2], wr [2];
      logic [12:0] ad [2];
      logic [3:0]  be [2];
      logic [31:0] wd [2];
      int          win;
      logic        exp_cs;
      logic [32:0] e;
      logic        ev [2];
      logic [31:0] ed [2];
      logic [31:0] old;

      #1;
      rd[0] = m0_if.read; wr[0] = m0_if.write; ad[0] = m0_if.address;
      be[0] = m0_if.byteenable; wd[0] = m0_if.writedata;
      rd[1] = m1_if.read; wr[1] = m1_if.write; ad[1] = m1_if.address;
      be[1] = m1_if.byteenable; wd[1] = m1_if.writedata;

      win = -1;
      if ((rd[0] | wr[0]) && (rd[1] | wr[1])) win = (last_win == 0) ? 1 : 0;
      else if (rd[0] | wr[0]) win = 0;
      else if (rd[1] | wr[1]) win = 1;
      exp_cs = (win >= 0) && !oob(ad[(win >= 0) ? win : 0]);

      got_wait[0] = m0_if.waitrequest;
      got_wait[1] = m1_if.waitrequest;
      got_cs      = ram_chipselect;
      checks += 3;
      if (m0_if.waitrequest !== (win != 0)) begin
         errors++; $display("FAIL waitreq_m0 t=%0t got=%b exp=%b", $time, m0_if.waitrequest, win != 0);
      end
      if (m1_if.waitrequest !== (win != 1)) begin
         errors++; $display("FAIL waitreq_m1 t=%0t got=%b exp=%b", $time, m1_if.waitrequest, win != 1);
      end
      if (ram_chipselect !== exp_cs) begin
         errors++; $display("FAIL chipselect t=%0t got=%b exp=%b", $time, ram_chipselect, exp_cs);
      end

      acc[0] = 1'b0; acc[1] = 1'b0;
      if (win >= 0) begin
         acc[win] = 1'b1;
         last_win = win;
         if (wr[win]) begin
            if (!oob(ad[win])) begin
               old = ref_read(ad[win]);
               for (int b = 0; b < 4; b++)
                  if (be[win][b]) old[8*b +: 8] = wd[win][8*b +: 8];
               ref_mem[int'(ad[win])] = old;
            end
         end else begin
            exp_q.push_back({(win == 1), oob(ad[win]) ? 32'hDEAD_BEEF : ref_read(ad[win])});
         end
      end

      @(posedge clk);
      #1;
      ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = '0; ed[1] = '0;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         ev[e[32]] = 1'b1;
         ed[e[32]] = e[31:0];
      end
      got_valid[0] = m0_if.readdatavalid; got_data[0] = m0_if.readdata;
      got_valid[1] = m1_if.readdatavalid; got_data[1] = m1_if.readdata;
      checks += 4;
      if (m0_if.readdatavalid !== ev[0]) begin
         errors++; $display("FAIL rdvalid_m0 t=%0t got=%b exp=%b", $time, m0_if.readdatavalid, ev[0]);
      end
      if (m1_if.readdatavalid !== ev[1]) begin
         errors++; $display("FAIL rdvalid_m1 t=%0t got=%b exp=%b", $time, m1_if.readdatavalid, ev[1]);
      end
      if (m0_if.readdata !== ed[0]) begin
         errors++; $display("FAIL rddata_m0 t=%0t got=%h exp=%h", $time, m0_if.readdata, ed[0]);
      end
      if (m1_if.readdata !== ed[1]) begin
         errors++; $display("FAIL rddata_m1 t=%0t got=%h exp=%h", $time, m1_if.readdata, ed[1]);
      end
      @(negedge clk);
   endtask

   // Issue one transfer from master m and wait (bounded) for acceptance.
   task automatic xfer(input int m, input logic rd, input logic wr, input logic [12:0] a,
                       input logic [3:0] be, input logic [31:0] d);
      bit done = 1'b0;
      drive(m, rd, wr, a, be, d);
      for (int i = 0; i < 4 && !done; i++) begin
         cycle();
         if (acc[m]) done = 1'b1;
      end
      drive(m, 1'b0, 1'b0, '0, '0, '0);
      checks++;
      if (!done) begin
         errors++; $display("FAIL xfer_timeout m%0d got=not_accepted exp=accepted", m);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      last_win = 1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drive(0, 1'b1, 1'b0, 13'h010, 4'hF, '0);
      drive(1, 1'b0, 1'b1, 13'h011, 4'hF, 32'h1);
      reset = 1'b1;
      @(negedge clk); #1;
      checks += 8;
      if (m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait_m0 got=%b exp=1", m0_if.waitrequest); end
      if (m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait_m1 got=%b exp=1", m1_if.waitrequest); end
      if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got=%b exp=0", ram_chipselect); end
      if (ram_write !== 1'b0) begin errors++; $display("FAIL rst_write got=%b exp=0", ram_write); end
      if (ram_clken !== 1'b0) begin errors++; $display("FAIL rst_clken got=%b exp=0", ram_clken); end
      if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin
         errors++; $display("FAIL rst_rdvalid got=%b%b exp=00", m1_if.readdatavalid, m0_if.readdatavalid);
      end
      if (m0_if.readdata !== 32'h0) begin errors++; $display("FAIL rst_rddata_m0 got=%h exp=0", m0_if.readdata); end
      if (m1_if.readdata !== 32'h0) begin errors++; $display("FAIL rst_rddata_m1 got=%h exp=0", m1_if.readdata); end
`ifdef ONCHIP_RAM_ARB_BOUNDS_CHECK_EN
      checks++;
      if (bounds_err !== 1'b0) begin errors++; $display("FAIL rst_bounds_err got=%b exp=0", bounds_err); end
`endif
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      do_reset();
      #1;
      checks++;
      if (ram_clken !== 1'b1) begin errors++; $display("FAIL clken_after_rst got=%b exp=1", ram_clken); end
      @(negedge clk);
   endtask

   task automatic test_single_master();
      xfer(0, 1'b0, 1'b1, 13'h010, 4'hF, 32'h1234_5678);
      xfer(0, 1'b1, 1'b0, 13'h010, 4'hF, 32'h0);
      checks += 3;
      if (got_valid[0] !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", got_valid[0]); end
      if (got_data[0] !== 32'h1234_5678) begin errors++; $display("FAIL single_data got=%h exp=12345678", got_data[0]); end
      if (got_valid[1] !== 1'b0) begin errors++; $display("FAIL single_m1_valid got=%b exp=0", got_valid[1]); end
   endtask

   task automatic test_contention();
      do_reset();
      drive(0, 1'b1, 1'b0, 13'h010, 4'hF, '0);
      drive(1, 1'b1, 1'b0, 13'h020, 4'hF, '0);
      for (int i = 0; i < 8; i++) begin
         cycle();
         checks += 3;
         if (got_wait[0] !== (i % 2 == 1)) begin
            errors++; $display("FAIL contend_wait_m0 i=%0d got=%b exp=%b", i, got_wait[0], i % 2 == 1);
         end
         if (got_wait[1] !== (i % 2 == 0)) begin
            errors++; $display("FAIL contend_wait_m1 i=%0d got=%b exp=%b", i, got_wait[1], i % 2 == 0);
         end
         if (got_valid[0] !== (i % 2 == 0)) begin
            errors++; $display("FAIL contend_route i=%0d got=%b exp=%b", i, got_valid[0], i % 2 == 0);
         end
      end
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      cycle();
   endtask

   task automatic test_byte_lanes();
      xfer(1, 1'b0, 1'b1, 13'h020, 4'hF, 32'hFFFF_FFFF);
      xfer(1, 1'b0, 1'b1, 13'h020, 4'b0001, 32'h0000_00AA);
      xfer(0, 1'b1, 1'b0, 13'h020, 4'hF, 32'h0);
      checks++;
      if (got_data[0] !== 32'hFFFF_FFAA) begin errors++; $display("FAIL byte_lanes got=%h exp=ffffffaa", got_data[0]); end
   endtask

   task automatic test_read_write_both();
      xfer(1, 1'b1, 1'b1, 13'h030, 4'hF, 32'h5A5A_5A5A);
      checks++;
      if (got_valid[1] !== 1'b0) begin errors++; $display("FAIL rw_no_resp got=%b exp=0", got_valid[1]); end
      xfer(1, 1'b1, 1'b0, 13'h030, 4'hF, 32'h0);
      checks++;
      if (got_data[1] !== 32'h5A5A_5A5A) begin errors++; $display("FAIL rw_readback got=%h exp=5a5a5a5a", got_data[1]); end
   endtask

   task automatic test_reset_mid_read();
      drive(0, 1'b1, 1'b0, 13'h010, 4'hF, '0);
      #1;
      checks++;
      if (m0_if.waitrequest !== 1'b0) begin errors++; $display("FAIL midrst_accept got=%b exp=0", m0_if.waitrequest); end
      @(posedge clk);
      #1 reset = 1'b1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      #1;
      checks++;
      if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", m0_if.readdatavalid); end
      exp_q.delete();
      last_win = 1;
      @(negedge clk);
      reset = 1'b0;
      drive(0, 1'b1, 1'b0, 13'h040, 4'hF, '0);
      drive(1, 1'b1, 1'b0, 13'h041, 4'hF, '0);
      cycle();
      checks += 2;
      if (got_wait[0] !== 1'b0) begin errors++; $display("FAIL midrst_m0_first got=%b exp=0", got_wait[0]); end
      if (got_wait[1] !== 1'b1) begin errors++; $display("FAIL midrst_m1_wait got=%b exp=1", got_wait[1]); end
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      cycle();
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      cycle();
   endtask

   task automatic test_random();
      bit pend [2];
      pend[0] = 1'b0; pend[1] = 1'b0;
      for (int n = 0; n < 300; n++) begin
         for (int m = 0; m < 2; m++) begin
            if (!pend[m]) begin
               if ($urandom_range(0, 9) < 6) begin
                  drive(m, 1'(($urandom_range(0, 2)) != 1), 1'($urandom_range(0, 2) != 0),
                        13'($urandom_range(0, 15) + 'h100), 4'($urandom_range(0, 15)), $urandom);
                  if (m == 0 && !(m0_if.read | m0_if.write)) m0_if.read = 1'b1;
                  if (m == 1 && !(m1_if.read | m1_if.write)) m1_if.read = 1'b1;
                  pend[m] = 1'b1;
               end else begin
                  drive(m, 1'b0, 1'b0, '0, '0, '0);
               end
            end
         end
         cycle();
         for (int m = 0; m < 2; m++) if (acc[m]) pend[m] = 1'b0;
      end
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      cycle();
   endtask

`ifdef ONCHIP_RAM_ARB_BOUNDS_CHECK_EN
   task automatic test_bounds();
      xfer(0, 1'b1, 1'b0, 13'd5120, 4'hF, '0);
      checks += 3;
      if (got_cs !== 1'b0) begin errors++; $display("FAIL bounds_cs got=%b exp=0", got_cs); end
      if (got_data[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bounds_data got=%h exp=deadbeef", got_data[0]); end
      if (bounds_err !== 1'b1) begin errors++; $display("FAIL bounds_err_set got=%b exp=1", bounds_err); end
      xfer(1, 1'b0, 1'b1, 13'h010, 4'hF, 32'hCAFE_0001);
      xfer(1, 1'b1, 1'b0, 13'h010, 4'hF, '0);
      checks++;
      if (bounds_err !== 1'b1) begin errors++; $display("FAIL bounds_err_sticky got=%b exp=1", bounds_err); end
   endtask
`endif

   // ---------------- main sequence / report ----------------
   initial begin
      reset = 1'b1;
      last_win = 1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      test_reset();
      test_single_master();
      test_contention();
      test_byte_lanes();
      test_read_write_both();
      test_reset_mid_read();
      test_random();
`ifdef ONCHIP_RAM_ARB_BOUNDS_CHECK_EN
      test_bounds();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
